ibex_dbg_insn_gen: RTL and testbench



---
 rtl/ibex_dbg_insn_gen.sv | 195 +++++++++++++++++++
 tb/tb_ibex_dbg_insn_gen.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_dbg_insn_gen.sv
// Debug instruction encoder: turns GPR/CSR access commands into RV32I words ending in EBREAK.
// Optional: define IBEX_DBG_INSN_GEN_FENCEI_EN to append FENCE.I to CSR_WRITE sequences.
module ibex_dbg_insn_gen #(
  parameter logic [11:0] DbgScratch0 = 12'h7b2,
  parameter logic [11:0] DbgScratch1 = 12'h7b3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_type_i,
  input  logic [11:0] cmd_regno_i,
  input  logic [31:0] cmd_data_i,
  output logic        insn_valid_o,
  input  logic        insn_ready_i,
  output logic [31:0] insn_o,
  output logic        insn_last_o,
  output logic        busy_o,
  output logic        err_o,
  input  logic        abort_i
);

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_e;
  typedef enum logic [1:0] {GPR_READ = 2'b00, GPR_WRITE = 2'b01,
                            CSR_READ = 2'b10, CSR_WRITE = 2'b11} cmd_e;

  localparam logic [31:0] Ebreak = 32'h00100073;
  localparam logic [31:0] FenceI = 32'h0000100F;
  localparam logic [4:0]  X0     = 5'd0;
  localparam logic [4:0]  X8     = 5'd8;

  function automatic logic [31:0] csrrw(input logic [11:0] csr, input logic [4:0] rs1,
                                        input logic [4:0] rd);
    return {csr, rs1, 3'b001, rd, 7'h73};
  endfunction

  function automatic logic [31:0] csrrs(input logic [11:0] csr, input logic [4:0] rs1,
                                        input logic [4:0] rd);
    return {csr, rs1, 3'b010, rd, 7'h73};
  endfunction

  // hi is rounded up when lo sign-extends negative, so LUI+ADDI rebuilds the exact value
  function automatic logic [31:0] lui(input logic [4:0] rd, input logic [31:0] d);
    logic [19:0] hi;
    hi = d[31:12] + {19'd0, d[11]};
    return {hi, rd, 7'h37};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [31:0] d);
    return {d[11:0], rd, 3'b000, rd, 7'h13};
  endfunction

  function automatic logic [2:0] last_step(input cmd_e t);
    case (t)
      GPR_READ:  return 3'd1;
      GPR_WRITE: return 3'd2;
      CSR_READ:  return 3'd4;
`ifdef IBEX_DBG_INSN_GEN_FENCEI_EN
      CSR_WRITE: return 3'd6;
`else
      CSR_WRITE: return 3'd5;
`endif
      default:   return 3'd1;
    endcase
  endfunction

  function automatic logic [31:0] gen_word(input cmd_e t, input logic [11:0] rg,
                                           input logic [31:0] d, input logic [2:0] k);
    logic [31:0] w;
    w = Ebreak;
    case (t)
      GPR_READ:  if (k == 3'd0) w = csrrw(DbgScratch0, rg[4:0], X0);
      GPR_WRITE: begin
        if (k == 3'd0) w = lui(rg[4:0], d);
        if (k == 3'd1) w = addi(rg[4:0], d);
      end
      CSR_READ: begin
        case (k)
          3'd0:    w = csrrw(DbgScratch1, X8, X0);
          3'd1:    w = csrrs(rg, X0, X8);
          3'd2:    w = csrrw(DbgScratch0, X8, X0);
          3'd3:    w = csrrs(DbgScratch1, X0, X8);
          default: w = Ebreak;
        endcase
      end
      CSR_WRITE: begin
        case (k)
          3'd0:    w = csrrw(DbgScratch1, X8, X0);
          3'd1:    w = lui(X8, d);
          3'd2:    w = addi(X8, d);
          3'd3:    w = csrrw(rg, X8, X0);
          3'd4:    w = csrrs(DbgScratch1, X0, X8);
`ifdef IBEX_DBG_INSN_GEN_FENCEI_EN
          3'd5:    w = FenceI;
`endif
          default: w = Ebreak;
        endcase
      end
      default: w = Ebreak;
    endcase
    return w;
  endfunction

  state_e      r_state, w_state_nxt;
  cmd_e        r_type, w_type_nxt;
  logic [11:0] r_regno, w_regno_nxt;
  logic [31:0] r_data, w_data_nxt;
  logic [2:0]  r_step, w_step_nxt;
  logic [31:0] r_insn, w_insn_nxt;
  logic        r_last, w_last_nxt;
  logic        r_valid, w_valid_nxt;
  logic        r_err, w_err_nxt;
  logic        w_hs;
  logic [2:0]  w_step_inc;

  assign w_hs       = r_valid && insn_ready_i;
  assign w_step_inc = r_step + 3'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_type_nxt  = r_type;
    w_regno_nxt = r_regno;
    w_data_nxt  = r_data;
    w_step_nxt  = r_step;
    w_insn_nxt  = r_insn;
    w_last_nxt  = r_last;
    w_valid_nxt = r_valid;
    w_err_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid_i) begin
          if (!cmd_type_i[1] && (cmd_regno_i[11:5] != '0)) begin
            w_err_nxt = 1'b1;
          end else begin
            w_type_nxt  = cmd_e'(cmd_type_i);
            w_regno_nxt = cmd_regno_i;
            w_data_nxt  = cmd_data_i;
            w_step_nxt  = '0;
            w_insn_nxt  = gen_word(cmd_e'(cmd_type_i), cmd_regno_i, cmd_data_i, 3'd0);
            w_last_nxt  = 1'b0;
            w_valid_nxt = 1'b1;
            w_state_nxt = EMIT;
          end
        end
      end
      EMIT: begin
        // abort wins over a handshake landing in the same cycle
        if (abort_i || (w_hs && r_last)) begin
          w_valid_nxt = 1'b0;
          w_insn_nxt  = '0;
          w_last_nxt  = 1'b0;
          w_state_nxt = DONE;
        end else if (w_hs) begin
          w_step_nxt = w_step_inc;
          w_insn_nxt = gen_word(r_type, r_regno, r_data, w_step_inc);
          w_last_nxt = (w_step_inc == last_step(r_type));
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_type  <= GPR_READ;
      r_regno <= '0;
      r_data  <= '0;
      r_step  <= '0;
      r_insn  <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_type  <= w_type_nxt;
      r_regno <= w_regno_nxt;
      r_data  <= w_data_nxt;
      r_step  <= w_step_nxt;
      r_insn  <= w_insn_nxt;
      r_last  <= w_last_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign cmd_ready_o  = (r_state == IDLE);
  assign busy_o       = (r_state != IDLE);
  assign insn_valid_o = r_valid;
  assign insn_o       = r_insn;
  assign insn_last_o  = r_last;
  assign err_o        = r_err;

endmodule

// File: tb/tb_ibex_dbg_insn_gen.sv
// Self-checking bench for ibex_dbg_insn_gen: vector table, corner sequences, random commands vs model.
module tb_ibex_dbg_insn_gen;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [1:0]  cmd_type_i = '0;
  logic [11:0] cmd_regno_i = '0;
  logic [31:0] cmd_data_i = '0;
  logic        insn_valid_o;
  logic        insn_ready_i = 1'b0;
  logic [31:0] insn_o;
  logic        insn_last_o;
  logic        busy_o;
  logic        err_o;
  logic        abort_i = 1'b0;

  always #5 clk = ~clk;

  ibex_dbg_insn_gen #(.DbgScratch0(12'h7b2), .DbgScratch1(12'h7b3)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_type_i(cmd_type_i), .cmd_regno_i(cmd_regno_i), .cmd_data_i(cmd_data_i),
    .insn_valid_o(insn_valid_o), .insn_ready_i(insn_ready_i), .insn_o(insn_o),
    .insn_last_o(insn_last_o), .busy_o(busy_o), .err_o(err_o), .abort_i(abort_i)
  );

  localparam logic [31:0] EBRK = 32'h00100073;
`ifdef IBEX_DBG_INSN_GEN_FENCEI_EN
  localparam int CSRW_N = 7;
`else
  localparam int CSRW_N = 6;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] got_q[$];
  logic        lst_q[$];
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] csr_op(input logic [11:0] csr, input int rs1, input int f3,
                                         input int rd);
    return (32'(csr) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'h73;
  endfunction

  // Reference sequence built from the command rules; hi uses round-to-nearest arithmetic
  function automatic void model(input int t, input logic [11:0] rg, input logic [31:0] d);
    logic [31:0] hi, lo;
    int rn;
    rn = int'(rg) % 32;
    hi = ((d + 32'h800) >> 12) & 32'hFFFFF;
    lo = d & 32'hFFF;
    exp_q.delete();
    case (t)
      0: exp_q.push_back(csr_op(12'h7b2, rn, 1, 0));
      1: begin
        exp_q.push_back((hi << 12) | (32'(rn) << 7) | 32'h37);
        exp_q.push_back((lo << 20) | (32'(rn) << 15) | (32'(rn) << 7) | 32'h13);
      end
      2: begin
        exp_q.push_back(csr_op(12'h7b3, 8, 1, 0));
        exp_q.push_back(csr_op(rg, 0, 2, 8));
        exp_q.push_back(csr_op(12'h7b2, 8, 1, 0));
        exp_q.push_back(csr_op(12'h7b3, 0, 2, 8));
      end
      default: begin
        exp_q.push_back(csr_op(12'h7b3, 8, 1, 0));
        exp_q.push_back((hi << 12) | (32'd8 << 7) | 32'h37);
        exp_q.push_back((lo << 20) | (32'd8 << 15) | (32'd8 << 7) | 32'h13);
        exp_q.push_back(csr_op(rg, 8, 1, 0));
        exp_q.push_back(csr_op(12'h7b3, 0, 2, 8));
`ifdef IBEX_DBG_INSN_GEN_FENCEI_EN
        exp_q.push_back(32'h0000100F);
`endif
      end
    endcase
    exp_q.push_back(EBRK);
  endfunction

  // Issue a command (caller at a negedge, DUT idle), collect handshaken words, then check DONE->IDLE.
  task automatic run_seq(input logic [1:0] t, input logic [11:0] rg, input logic [31:0] d,
                         input bit rnd, input int stall_first, input int abort_idx,
                         output int cyc);
    int guard, stalls;
    bit rdy, ab, held;
    logic [31:0] prev_insn;
    logic prev_last;
    got_q.delete(); lst_q.delete();
    chk("cmd_ready_idle", cmd_ready_o, 1);
    cmd_valid_i = 1'b1; cmd_type_i = t; cmd_regno_i = rg; cmd_data_i = d;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    chk("first_valid", insn_valid_o, 1);
    chk("busy_emit", busy_o, 1);
    cyc = 0; guard = 0; stalls = 0; held = 1'b0; prev_insn = '0; prev_last = 1'b0;
    while (insn_valid_o && guard < 300) begin
      if (held) begin
        chk("hold_insn", insn_o, prev_insn);
        chk("hold_last", insn_last_o, prev_last);
      end
      if (rnd) rdy = bit'($urandom_range(0, 1));
      else if (got_q.size() == 0 && stalls < stall_first) begin rdy = 1'b0; stalls++; end
      else rdy = 1'b1;
      ab = (got_q.size() == abort_idx);
      if (ab) rdy = 1'b1;
      insn_ready_i = rdy; abort_i = ab;
      if (rdy && !ab) begin got_q.push_back(insn_o); lst_q.push_back(insn_last_o); end
      held = !rdy; prev_insn = insn_o; prev_last = insn_last_o;
      cyc++; guard++;
      @(negedge clk);
      insn_ready_i = 1'b0; abort_i = 1'b0;
    end
    if (guard >= 300) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: insn_valid_o still 1 after %0d cycles, required 0", guard);
    end
    chk("done_cmd_ready", cmd_ready_o, 0);
    chk("done_busy", busy_o, 1);
    @(negedge clk);
    chk("back_cmd_ready", cmd_ready_o, 1);
    chk("back_busy", busy_o, 0);
  endtask

  task automatic cmp_seq(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
      chk($sformatf("%s_last%0d", tag, i), lst_q[i], (i == exp_q.size() - 1) ? 1 : 0);
    end
  endtask

  task automatic err_cmd(input logic [1:0] t, input logic [11:0] rg);
    cmd_valid_i = 1'b1; cmd_type_i = t; cmd_regno_i = rg; cmd_data_i = 32'hDEADBEEF;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    chk("err_pulse", err_o, 1);
    chk("err_no_valid", insn_valid_o, 0);
    chk("err_ready", cmd_ready_o, 1);
    chk("err_busy", busy_o, 0);
    @(negedge clk);
    chk("err_clear", err_o, 0);
    chk("err_no_valid2", insn_valid_o, 0);
  endtask

  typedef struct {
    logic [1:0]  t;
    logic [11:0] rg;
    logic [31:0] d;
    int          n;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int cyc;
    vecs[0] = '{2'd1, 12'd5,    32'h12345FFF, 3,      32'h123462B7, 32'hFFF28293};
    vecs[1] = '{2'd1, 12'd5,    32'hFFFFF800, 3,      32'h000002B7, 32'h80028293};
    vecs[2] = '{2'd0, 12'd10,   32'h0,        2,      32'h7B251073, EBRK};
    vecs[3] = '{2'd2, 12'h340,  32'h0,        5,      32'h7B341073, 32'h34002473};
    vecs[4] = '{2'd3, 12'h300,  32'h0,        CSRW_N, 32'h7B341073, 32'h00000437};
    vecs[5] = '{2'd1, 12'd0,    32'h00000001, 3,      32'h00000037, 32'h00100013};

    #1;
    chk("rst_cmd_ready", cmd_ready_o, 1);
    chk("rst_valid", insn_valid_o, 0);
    chk("rst_insn", insn_o, 0);
    chk("rst_last", insn_last_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      run_seq(vecs[v].t, vecs[v].rg, vecs[v].d, 1'b0, 0, -1, cyc);
      chk($sformatf("vec%0d_count", v), got_q.size(), vecs[v].n);
      chk($sformatf("vec%0d_cycles", v), cyc, vecs[v].n);
      if (got_q.size() >= 2) begin
        chk($sformatf("vec%0d_w0", v), got_q[0], vecs[v].w0);
        chk($sformatf("vec%0d_w1", v), got_q[1], vecs[v].w1);
        chk($sformatf("vec%0d_ebreak", v), got_q[got_q.size()-1], EBRK);
      end
      for (int i = 0; i < lst_q.size(); i++)
        chk($sformatf("vec%0d_last%0d", v, i), lst_q[i], (i == vecs[v].n - 1) ? 1 : 0);
    end

    // stalled GPR_READ: word 0 held 3 cycles
    run_seq(2'd0, 12'd10, 32'h0, 1'b0, 3, -1, cyc);
    chk("stall_cycles", cyc, 5);
    chk("stall_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("stall_w0", got_q[0], 32'h7B251073);
      chk("stall_w1", got_q[1], EBRK);
    end

    // abort during word 2 of CSR_WRITE, with a simultaneous ready
    run_seq(2'd3, 12'h300, 32'h00001234, 1'b0, 0, 2, cyc);
    chk("abort_count", got_q.size(), 2);
    chk("abort_cycles", cyc, 3);

`ifdef IBEX_DBG_INSN_GEN_FENCEI_EN
    run_seq(2'd3, 12'h300, 32'h00001234, 1'b0, 0, -1, cyc);
    chk("fencei_count", got_q.size(), 7);
    if (got_q.size() == 7) chk("fencei_w5", got_q[5], 32'h0000100F);
`endif

    err_cmd(2'd0, 12'h020);
    err_cmd(2'd1, 12'hF05);

    // asynchronous reset mid-sequence
    cmd_valid_i = 1'b1; cmd_type_i = 2'd2; cmd_regno_i = 12'h340; cmd_data_i = '0;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    chk("pre_rst_valid", insn_valid_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("mid_rst_valid", insn_valid_o, 0);
    chk("mid_rst_insn", insn_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_ready", cmd_ready_o, 1);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);

    for (int n = 0; n < 60; n++) begin
      int t;
      logic [11:0] rg;
      logic [31:0] d;
      t = $urandom_range(0, 3);
      d = $urandom();
      if ($urandom_range(0, 4) == 0) d = d | 32'hFFFFF800;
      if (t < 2) rg = ($urandom_range(0, 7) == 0) ? 12'($urandom_range(32, 4095))
                                                  : 12'($urandom_range(0, 31));
      else rg = 12'($urandom());
      if (t < 2 && rg >= 12'd32) begin
        err_cmd(2'(t), rg);
      end else begin
        model(t, rg, d);
        run_seq(2'(t), rg, d, 1'b1, 0, -1, cyc);
        cmp_seq($sformatf("rnd%0d", n));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
